// File: rtl/pi_ctrl_mc.sv
// Time-multiplexed PI controller: one shared multiplier pair steps NCH channels
// through ERR/MUL/SAT/INT/OUT, five cycles per channel, with clamp and anti-windup.
module pi_ctrl_mc #(
   parameter int NCH  = 2,
   parameter int DW   = 16,
   parameter int GW   = 32,
   parameter int AW   = 32,
   parameter int FRAC = 10
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start_i,
   input  logic                clr_i,
   input  logic [NCH*DW-1:0]   ref_i,
   input  logic [NCH*DW-1:0]   feed_i,
   input  logic [NCH*GW-1:0]   kp_i,
   input  logic [NCH*GW-1:0]   ki_i,
   input  logic [DW-2:0]       lim_i,
   output logic                busy_o,
   output logic                done_o,
   output logic [NCH*DW-1:0]   out_o,
   output logic [2*NCH-1:0]    sat_o
);
   localparam int PW = GW + DW + 1;
   localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam logic signed [AW-1:0] AMAX = {1'b0, {(AW-1){1'b1}}};
   localparam logic signed [AW-1:0] AMIN = {1'b1, {(AW-1){1'b0}}};
   localparam logic signed [AW:0]   RND  = (AW+1)'(1) << (FRAC-1);

   typedef enum logic [2:0] {IDLE, ERR, MUL, SAT, INT, OUT, DONE} state_t;

   state_t                 state_q;
   logic [CW-1:0]          ch_q;
   logic [NCH*DW-1:0]      ref_q, feed_q, out_q;
   logic [NCH*GW-1:0]      kp_q, ki_q;
   logic [DW-2:0]          lim_q;
   logic [2*NCH-1:0]       sat_q;
   logic signed [DW:0]     e_q;
   logic signed [PW-1:0]   pp_q, ip_q;
   logic signed [AW-1:0]   ps_q, is_q;
   logic signed [AW-1:0]   integ_q [NCH];
   logic                   busy_q, done_q;

   // Clip a full-precision product: in range only if all bits above AW-1 match the sign.
   function automatic logic signed [AW-1:0] sat_prod(input logic signed [PW-1:0] x);
      logic [PW-AW:0] top;
      top = x[PW-1:AW-1];
      if (top == '0 || top == '1) return x[AW-1:0];
      else if (x[PW-1])           return AMIN;
      else                        return AMAX;
   endfunction

   function automatic logic signed [AW-1:0] sat_sum(input logic signed [AW-1:0] a,
                                                     input logic signed [AW-1:0] b);
      logic signed [AW:0] t;
      t = a + b;
      if (t[AW] != t[AW-1]) return t[AW] ? AMIN : AMAX;
      return t[AW-1:0];
   endfunction

   logic signed [DW-1:0]   ref_c, feed_c;
   logic signed [GW-1:0]   kp_c, ki_c;
   logic [1:0]             flag_c;
   logic signed [AW-1:0]   integ_c;

   assign ref_c   = ref_q[int'(ch_q)*DW +: DW];
   assign feed_c  = feed_q[int'(ch_q)*DW +: DW];
   assign kp_c    = kp_q[int'(ch_q)*GW +: GW];
   assign ki_c    = ki_q[int'(ch_q)*GW +: GW];
   assign flag_c  = sat_q[2*int'(ch_q) +: 2];
   assign integ_c = integ_q[ch_q];

   logic signed [DW:0]     e_d;
   logic signed [PW-1:0]   pp_d, ip_d;
   logic signed [AW-1:0]   ps_d, is_d, integ_d, s_d;
   logic signed [AW:0]     r_d, lim_s, lim_n;
   logic signed [DW-1:0]   out_d;
   logic [1:0]             flag_d;
   logic                   hold;

   always_comb begin
      e_d     = ref_c - feed_c;
      pp_d    = kp_c * e_q;
      ip_d    = ki_c * e_q;
      ps_d    = sat_prod(pp_q);
      is_d    = sat_prod(ip_q);
      // Stop integrating further into a clamp seen on this channel's previous run.
      hold    = (flag_c == 2'b01 && !e_q[DW] && e_q != '0) || (flag_c == 2'b11 && e_q[DW]);
      integ_d = hold ? integ_c : sat_sum(integ_c, is_q);
      s_d     = sat_sum(ps_q, integ_c);
      r_d     = s_d;
      r_d     = (r_d + RND) >>> FRAC;
      lim_s   = {{(AW+2-DW){1'b0}}, lim_q};
      lim_n   = -lim_s;
      out_d   = r_d[DW-1:0];
      flag_d  = 2'b00;
      if (r_d > lim_s) begin
         out_d  = lim_s[DW-1:0];
         flag_d = 2'b01;
      end else if (r_d < lim_n) begin
         out_d  = lim_n[DW-1:0];
         flag_d = 2'b11;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ch_q    <= '0;
         ref_q   <= '0;
         feed_q  <= '0;
         kp_q    <= '0;
         ki_q    <= '0;
         lim_q   <= '0;
         out_q   <= '0;
         sat_q   <= '0;
         e_q     <= '0;
         pp_q    <= '0;
         ip_q    <= '0;
         ps_q    <= '0;
         is_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         for (int k = 0; k < NCH; k++) integ_q[k] <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (clr_i) begin
                  sat_q <= '0;
                  for (int k = 0; k < NCH; k++) integ_q[k] <= '0;
               end else if (start_i) begin
                  ref_q   <= ref_i;
                  feed_q  <= feed_i;
                  kp_q    <= kp_i;
                  ki_q    <= ki_i;
                  lim_q   <= lim_i;
                  ch_q    <= '0;
                  busy_q  <= 1'b1;
                  state_q <= ERR;
               end
            end
            ERR: begin
               e_q     <= e_d;
               state_q <= MUL;
            end
            MUL: begin
               pp_q    <= pp_d;
               ip_q    <= ip_d;
               state_q <= SAT;
            end
            SAT: begin
               ps_q    <= ps_d;
               is_q    <= is_d;
               state_q <= INT;
            end
            INT: begin
               integ_q[ch_q] <= integ_d;
               state_q       <= OUT;
            end
            OUT: begin
               out_q[int'(ch_q)*DW +: DW] <= out_d;
               sat_q[2*int'(ch_q) +: 2]   <= flag_d;
               if (ch_q == CW'(NCH-1)) begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end else begin
                  ch_q    <= ch_q + 1'b1;
                  state_q <= ERR;
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy_o = busy_q;
   assign done_o = done_q;
   assign out_o  = out_q;
   assign sat_o  = sat_q;
endmodule

// File: tb/tb_pi_ctrl_mc.sv
// Bench for pi_ctrl_mc: directed and random runs scored against an arithmetic PI model.
module tb_pi_ctrl_mc;
   localparam int NCH = 2, DW = 16, GW = 32, AW = 32, FRAC = 10;
   localparam longint AMAXL = (64'sd1 <<< (AW-1)) - 1;
   localparam longint AMINL = -(64'sd1 <<< (AW-1));

   logic clk = 1'b0, rst_n = 1'b0, start_i = 1'b0, clr_i = 1'b0;
   logic [NCH*DW-1:0] ref_i = '0, feed_i = '0;
   logic [NCH*GW-1:0] kp_i = '0, ki_i = '0;
   logic [DW-2:0]     lim_i = '0;
   logic              busy_o, done_o;
   logic [NCH*DW-1:0] out_o;
   logic [2*NCH-1:0]  sat_o;

   pi_ctrl_mc #(.NCH(NCH), .DW(DW), .GW(GW), .AW(AW), .FRAC(FRAC)) dut (
      .clk(clk), .rst_n(rst_n), .start_i(start_i), .clr_i(clr_i),
      .ref_i(ref_i), .feed_i(feed_i), .kp_i(kp_i), .ki_i(ki_i), .lim_i(lim_i),
      .busy_o(busy_o), .done_o(done_o), .out_o(out_o), .sat_o(sat_o));

   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { logic [NCH*DW-1:0] out; logic [2*NCH-1:0] sat; int dcyc; } exp_t;
   exp_t sb[$];
   int checks = 0, errors = 0, done_cnt = 0, exp_done = 0;

   int refv[NCH], feedv[NCH], kpv[NCH], kiv[NCH], limv;
   longint m_integ[NCH];
   logic [1:0] m_flag[NCH];
   logic [NCH*DW-1:0] m_out = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic longint satw(input longint x);
      if (x > AMAXL) return AMAXL;
      if (x < AMINL) return AMINL;
      return x;
   endfunction

   function automatic logic [2*NCH-1:0] m_flags();
      logic [2*NCH-1:0] f;
      for (int k = 0; k < NCH; k++) f[2*k +: 2] = m_flag[k];
      return f;
   endfunction

   // Reference PI step for every channel, straight from the controller equations.
   task automatic model_run();
      for (int k = 0; k < NCH; k++) begin
         longint e, p, i, s, r, lim, o;
         logic [1:0] f;
         e = longint'(refv[k]) - longint'(feedv[k]);
         p = satw(longint'(kpv[k]) * e);
         i = satw(longint'(kiv[k]) * e);
         if (!((m_flag[k] == 2'b01 && e > 0) || (m_flag[k] == 2'b11 && e < 0)))
            m_integ[k] = satw(m_integ[k] + i);
         s = satw(p + m_integ[k]);
         r = (s + (64'sd1 <<< (FRAC-1))) >>> FRAC;
         lim = longint'(limv);
         if (r > lim)       begin o = lim;  f = 2'b01; end
         else if (r < -lim) begin o = -lim; f = 2'b11; end
         else               begin o = r;    f = 2'b00; end
         m_out[k*DW +: DW] = DW'(o);
         m_flag[k] = f;
      end
   endtask

   task automatic model_clear();
      for (int k = 0; k < NCH; k++) begin m_integ[k] = 0; m_flag[k] = 2'b00; end
   endtask

   task automatic apply();
      for (int k = 0; k < NCH; k++) begin
         ref_i[k*DW +: DW]  = DW'(refv[k]);
         feed_i[k*DW +: DW] = DW'(feedv[k]);
         kp_i[k*GW +: GW]   = GW'(kpv[k]);
         ki_i[k*GW +: GW]   = GW'(kiv[k]);
      end
      lim_i = (DW-1)'(limv);
   endtask

   task automatic scramble();
      for (int k = 0; k < NCH; k++) begin
         ref_i[k*DW +: DW]  = DW'($urandom);
         feed_i[k*DW +: DW] = DW'($urandom);
         kp_i[k*GW +: GW]   = GW'($urandom);
         ki_i[k*GW +: GW]   = GW'($urandom);
      end
      lim_i = (DW-1)'($urandom);
   endtask

   task automatic run(input bit timing, input bit poke);
      exp_t x;
      int a, guard;
      logic [DW-1:0] prev0;
      prev0 = m_out[DW-1:0];
      model_run();
      x.out = m_out;
      x.sat = m_flags();
      @(negedge clk);
      apply();
      start_i = 1'b1;
      a = cyc + 1;
      x.dcyc = a + 5*NCH;
      sb.push_back(x);
      exp_done++;
      @(negedge clk);
      start_i = 1'b0;
      scramble();
      if (timing) check("busy_cycle1", 64'(busy_o), 64'd1);
      guard = 0;
      while (!done_o && guard < 200) begin
         if (timing && cyc == a + 4) check("out0_cycle5_old", 64'(out_o[DW-1:0]), 64'(prev0));
         if (timing && cyc == a + 5) check("out0_cycle6_new", 64'(out_o[DW-1:0]), 64'(x.out[DW-1:0]));
         if (poke) begin
            start_i = (cyc == a + 3);
            clr_i   = (cyc == a + 3);
         end
         @(negedge clk);
         guard++;
      end
      start_i = 1'b0;
      clr_i   = 1'b0;
      if (guard >= 200) begin
         checks++;
         errors++;
         $display("FAIL done_timeout: no done_o within 200 cycles");
      end
      @(negedge clk);
   endtask

   task automatic clear(input bit also_start);
      logic bad;
      @(negedge clk);
      clr_i = 1'b1;
      start_i = also_start;
      apply();
      @(negedge clk);
      clr_i = 1'b0;
      start_i = 1'b0;
      model_clear();
      bad = 1'b0;
      repeat (8) begin
         if (busy_o || done_o) bad = 1'b1;
         @(negedge clk);
      end
      check("clr_no_run", 64'(bad), 64'd0);
      check("clr_out_kept", 64'(out_o), 64'(m_out));
      check("clr_sat_zero", 64'(sat_o), 64'd0);
   endtask

   always @(negedge clk) begin
      if (rst_n && done_o) begin
         exp_t x;
         done_cnt++;
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: done_o with no run pending at cycle %0d", cyc);
         end else begin
            x = sb.pop_front();
            check("out", 64'(out_o), 64'(x.out));
            check("sat", 64'(sat_o), 64'(x.sat));
            check("done_cycle", 64'(cyc), 64'(x.dcyc));
            check("busy_at_done", 64'(busy_o), 64'd0);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int a, dc;
      logic bad;
      model_clear();
      repeat (3) @(negedge clk);
      check("rst_out", 64'(out_o), 64'd0);
      check("rst_sat", 64'(sat_o), 64'd0);
      check("rst_busy_done", 64'({busy_o, done_o}), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Proportional ch0, integrating ch1
      refv = '{1000, 100}; feedv = '{0, 0}; kpv = '{1024, 0}; kiv = '{0, 1024}; limv = 32767;
      run(1, 0);
      check("p_out0", 64'(out_o[15:0]), 64'd1000);
      check("i_out1_run1", 64'(out_o[31:16]), 64'd100);
      run(0, 0);
      check("i_out1_run2", 64'(out_o[31:16]), 64'd200);
      run(0, 0);
      check("i_out1_run3", 64'(out_o[31:16]), 64'd300);
      check("i_sat_none", 64'(sat_o), 64'd0);

      // Clamp and anti-windup
      clear(0);
      refv = '{1000, 0}; kpv = '{102400, 0}; kiv = '{1024, 0}; limv = 20000;
      run(0, 0);
      check("clamp_out0", 64'(out_o[15:0]), 64'd20000);
      check("clamp_flag0", 64'(sat_o[1:0]), 64'b01);
      run(0, 0);
      check("windup_out0", 64'(out_o[15:0]), 64'd20000);
      refv[0] = -1000;
      run(0, 0);
      check("unwind_out0", 64'(out_o[15:0]), 64'hB1E0);

      // Product saturation
      refv = '{-32768, 0}; feedv = '{32767, 0}; kpv = '{32'h7FFFFFFF, 0}; kiv = '{0, 0}; limv = 32767;
      run(0, 0);
      check("psat_out0", 64'(out_o[15:0]), 64'h8001);
      check("psat_flag0", 64'(sat_o[1:0]), 64'b11);

      // Zero limit forces zero outputs
      refv = '{12345, -22222}; feedv = '{-300, 999}; kpv = '{int'($urandom), 5000}; kiv = '{777, int'($urandom)};
      limv = 0;
      run(0, 0);
      check("lim0_out", 64'(out_o), 64'd0);

      // clr wins over start; integrator restarts from zero
      clear(1);
      refv = '{0, 100}; feedv = '{0, 0}; kpv = '{0, 0}; kiv = '{0, 1024}; limv = 32767;
      run(0, 0);
      check("after_clr_out1", 64'(out_o[31:16]), 64'd100);

      // start/clr during a run are ignored
      dc = done_cnt;
      run(0, 1);
      repeat (15) @(negedge clk);
      check("poke_done_count", 64'(done_cnt), 64'(dc + 1));

      // Reset mid-run at cycle 3
      refv = '{500, -700}; kpv = '{2048, 3000}; kiv = '{100, 200};
      @(negedge clk);
      apply();
      start_i = 1'b1;
      a = cyc + 1;
      @(negedge clk);
      start_i = 1'b0;
      while (cyc < a + 2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      model_clear();
      m_out = '0;
      check("midrst_out", 64'(out_o), 64'd0);
      check("midrst_sat", 64'(sat_o), 64'd0);
      check("midrst_busy_done", 64'({busy_o, done_o}), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      bad = 1'b0;
      repeat (12) begin
         if (busy_o || done_o) bad = 1'b1;
         @(negedge clk);
      end
      check("midrst_idle", 64'(bad), 64'd0);
      run(0, 0);

      // Randomized runs
      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 7) == 0) clear(0);
         for (int k = 0; k < NCH; k++) begin
            refv[k]  = int'($urandom_range(0, 65535)) - 32768;
            feedv[k] = int'($urandom_range(0, 65535)) - 32768;
            kpv[k]   = ($urandom_range(0, 3) == 0) ? int'($urandom) : int'($urandom_range(0, 8192)) - 4096;
            kiv[k]   = ($urandom_range(0, 3) == 0) ? int'($urandom) : int'($urandom_range(0, 1024)) - 512;
         end
         limv = int'($urandom_range(0, 32767));
         run(0, (n % 10) == 3);
      end

      repeat (5) @(negedge clk);
      check("done_count", 64'(done_cnt), 64'(exp_done));
      check("scoreboard_empty", 64'(sb.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
